multiplier_32: RTL and testbench

Unsigned 32x32 -> 64-bit sequential shift-add multiplier, the inverse datapath to the team's combinational unsigned 32-bit divider. It accepts one operand pair through a valid/ready handshake, iterates one partial product per clock over a fixed 32 cycles, and holds the full 64-bit product until a downstream consumer accepts it. It sits beside the divider in the arithmetic unit. Benches check it against the divider: the divider applied to the product's low word and a nonzero operand recovers the other operand when the high word is zero.

---
 rtl/multiplier_32.sv | 141 ++++++++++++++
 tb/tb_multiplier_32.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/multiplier_32.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// multiplier_32
//
// Unsigned WIDTH x WIDTH -> 2*WIDTH sequential shift-add multiplier.
// One operand pair is accepted through a valid/ready handshake. One partial
// product is folded in per clock over exactly WIDTH cycles. The full product
// is then held until the consumer takes it.
//
// Ports:
//   clk        in   1         sole clock, rising edge
//   rst_n      in   1         synchronous active-low reset
//   in_valid   in   1         operand pair on a/b is valid
//   in_ready   out  1         block can accept an operand pair (IDLE only)
//   a          in   WIDTH     multiplicand, unsigned
//   b          in   WIDTH     multiplier, unsigned
//   out_valid  out  1         product is valid (DONE only)
//   out_ready  in   1         consumer accepts product
//   product    out  2*WIDTH   registered unsigned a*b
//   busy       out  1         high in RUN and DONE
// ---------------------------------------------------------------------------
module multiplier_32 #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_nextState;
    logic [WIDTH-1:0]      r_mcand;
    logic [2*WIDTH:0]      r_acc;
    logic [CW-1:0]         r_count;
    logic [2*WIDTH-1:0]    r_product;
    logic [WIDTH:0]        w_sum;
    logic [2*WIDTH:0]      w_accNext;
    logic                  w_lastIter;

    // The last iteration is the one where the counter reads WIDTH-1; that
    // edge both finishes the accumulation and captures the product.
    assign w_lastIter = (r_count == CW'(WIDTH - 1));

    // One shift-add step. The upper half plus the multiplicand is formed as
    // a WIDTH+1 bit sum so the carry lands in the top accumulator bit; the
    // whole accumulator then shifts right with a zero fill.
    always_comb begin
        w_sum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_mcand};
        w_accNext = {1'b0, r_acc[2*WIDTH:1]};
        if (r_acc[0]) begin
            w_accNext = {1'b0, w_sum, r_acc[WIDTH-1:1]};
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic. in_valid only matters in IDLE and out_ready only in
    // DONE, so neither handshake can complete outside its own state.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: if (in_valid)   w_nextState = RUN;
            RUN:  if (w_lastIter) w_nextState = DONE;
            DONE: if (out_ready)  w_nextState = IDLE;
            default:              w_nextState = IDLE;
        endcase
    end

    // Output decode: all handshake outputs are pure functions of state so
    // there is no combinational path from in_valid or out_ready.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (r_state)
            IDLE: in_ready = 1'b1;
            RUN:  busy     = 1'b1;
            DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: in_ready = 1'b0;
        endcase
    end

    // Datapath. Operands are captured only on the accept edge; the product
    // register is written only on the final iteration and otherwise holds,
    // so it stays stable through DONE and after returning to IDLE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mcand   <= '0;
            r_acc     <= '0;
            r_count   <= '0;
            r_product <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_mcand <= a;
                        r_acc   <= {{(WIDTH+1){1'b0}}, b};
                        r_count <= '0;
                    end
                end
                RUN: begin
                    r_acc   <= w_accNext;
                    r_count <= r_count + 1'b1;
                    if (w_lastIter) begin
                        r_product <= w_accNext[2*WIDTH-1:0];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign product = r_product;

endmodule

// File: tb/tb_multiplier_32.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_multiplier_32
//
// Self-checking bench for multiplier_32. It uses directed vectors with
// hand-computed products, handshake timing checks, backpressure, a reset
// issued mid-operation and a block of random pairs. Products whose high
// word is zero are also checked by dividing the low word by b, which must
// give back a with no remainder.
// ---------------------------------------------------------------------------
module tb_multiplier_32;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] product;
    logic        busy;

    int assertCount = 0;
    int failCount   = 0;

    multiplier_32 #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    // 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the handshake logic wedges somewhere unbounded.
    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: observed simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Runs one multiply: waits for in_ready, presents the pair for one edge,
    // then counts edges (including the accept edge) until out_valid shows.
    // With randomReady set it also drains DONE with a random out_ready,
    // checking the product stays put; otherwise it returns in the first
    // DONE cycle and leaves out_ready to the caller.
    task automatic applyStimulus(input logic [31:0] aIn, input logic [31:0] bIn,
                                 input bit randomReady,
                                 output logic [63:0] prodOut, output int latency);
        int guard;
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        checkOutput("acceptReady", 64'(in_ready), 64'd1);
        a        = aIn;
        b        = bIn;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a        = $urandom;
        b        = $urandom;
        latency  = 1;
        while (!out_valid && latency < 200) begin
            if (randomReady) out_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            latency++;
        end
        checkOutput("doneReached", 64'(out_valid), 64'd1);
        prodOut = product;
        if (randomReady) begin
            guard = 0;
            while (out_valid && guard < 64) begin
                checkOutput("holdStable", product, prodOut);
                out_ready = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
                guard++;
            end
            checkOutput("drainDone", 64'(out_valid), 64'd0);
        end
    endtask

    initial begin
        logic [63:0] prod;
        logic [63:0] heldProd;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] quot;
        logic [31:0] rem;
        int          lat;
        bit          sawValid;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;

        // Reset then idle.
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        checkOutput("rstInReady",  64'(in_ready),  64'd1);
        checkOutput("rstOutValid", 64'(out_valid), 64'd0);
        checkOutput("rstBusy",     64'(busy),      64'd0);
        checkOutput("rstProduct",  product,        64'd0);

        // Basic multiply with latency and turnaround.
        out_ready = 1'b1;
        applyStimulus(32'd7, 32'd6, 1'b0, prod, lat);
        checkOutput("basicLatency", 64'(lat), 64'd33);
        checkOutput("basicProduct", prod, 64'd42);
        checkOutput("basicBusy",    64'(busy), 64'd1);
        checkOutput("basicNoReady", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        checkOutput("basicReadyBack", 64'(in_ready), 64'd1);
        checkOutput("basicValidDrop", 64'(out_valid), 64'd0);
        checkOutput("basicProdHeld",  product, 64'd42);

        // Max operands and carry into the high word.
        applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, prod, lat);
        checkOutput("maxProduct", prod, 64'hFFFF_FFFE_0000_0001);
        applyStimulus(32'h8000_0000, 32'd2, 1'b0, prod, lat);
        checkOutput("msbTimesTwo", prod, 64'h0000_0001_0000_0000);

        // Zero and identity still take the full latency.
        applyStimulus(32'd0, 32'hDEAD_BEEF, 1'b0, prod, lat);
        checkOutput("zeroLatency", 64'(lat), 64'd33);
        checkOutput("zeroProduct", prod, 64'd0);
        applyStimulus(32'h1234_5678, 32'd1, 1'b0, prod, lat);
        checkOutput("identLatency", 64'(lat), 64'd33);
        checkOutput("identProduct", prod, 64'h0000_0000_1234_5678);

        // Backpressure while the inputs are wiggled.
        @(posedge clk); #1;
        out_ready = 1'b0;
        applyStimulus(32'd100000, 32'd300000, 1'b0, prod, lat);
        checkOutput("bpProduct", prod, 64'h0000_0006_FC23_AC00);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            a        = $urandom;
            b        = $urandom;
            @(posedge clk); #1;
            checkOutput("bpValidHeld", 64'(out_valid), 64'd1);
            checkOutput("bpProdHeld",  product, 64'h0000_0006_FC23_AC00);
            checkOutput("bpNoAccept",  64'(in_ready), 64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        checkOutput("bpReleaseReady", 64'(in_ready),  64'd1);
        checkOutput("bpReleaseBusy",  64'(busy),      64'd0);
        checkOutput("bpReleaseValid", 64'(out_valid), 64'd0);
        checkOutput("bpReleaseProd",  product, 64'h0000_0006_FC23_AC00);

        // Reset in the middle of RUN discards the operation.
        a        = 32'd5;
        b        = 32'd9;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checkOutput("midRunBusy", 64'(busy), 64'd1);
        repeat (15) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checkOutput("midRstReady",   64'(in_ready),  64'd1);
        checkOutput("midRstValid",   64'(out_valid), 64'd0);
        checkOutput("midRstBusy",    64'(busy),      64'd0);
        checkOutput("midRstProduct", product,        64'd0);
        sawValid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) sawValid = 1'b1;
        end
        checkOutput("midRstNoValid", 64'(sawValid), 64'd0);

        // Random pairs with random downstream readiness.
        for (int i = 0; i < 1000; i++) begin
            if (i % 4 == 0) begin
                ra = 32'($urandom_range(0, 65535));
                rb = 32'($urandom_range(0, 65535));
            end else begin
                ra = $urandom;
                rb = $urandom;
            end
            applyStimulus(ra, rb, 1'b1, heldProd, lat);
            checkOutput("randProduct", heldProd, 64'(ra) * 64'(rb));
            if (heldProd[63:32] == 32'd0 && rb != 32'd0) begin
                quot = heldProd[31:0] / rb;
                rem  = heldProd[31:0] % rb;
                checkOutput("divQuotient",  64'(quot), 64'(ra));
                checkOutput("divRemainder", 64'(rem),  64'd0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
